rr_req_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource among 16 requesters.
- Grants exactly one owner at a time, using a rotating-priority encoder that yields a one-hot grant plus a 4-bit index.
- The grant is held until the owner drops its request, or a hold timeout forces rotation under contention.
- Sits in front of the shared datapath; the index output drives its source mux.

---
 rtl/rr_req_arbiter_pkg.sv | 13 +
 rtl/rr_req_arbiter_pick.sv | 34 +++
 rtl/rr_req_arbiter.sv | 96 +++++++++
 tb/tb_rr_req_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_req_arbiter_pkg.sv
// Shared constants and state type for the round-robin request arbiter.
package arb_pkg;

  localparam int N_REQ        = 16;
  localparam int IDXW         = 4;
  localparam int NO_GRANT_IDX = 0;

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

endpackage

// File: rtl/rr_req_arbiter_pick.sv
// Rotating-priority picker: the search runs from ptr-1 downwards and wraps,
// so index ptr itself has the lowest priority.
module rr_pick #(
  parameter int N    = arb_pkg::N_REQ,
  parameter int IDXW = arb_pkg::IDXW
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] win_idx
);

  logic [2*N-1:0]  doubled;
  logic [N-1:0]    rot;
  logic [IDXW-1:0] rot_idx;

  // rot[j] is req[(ptr + j) mod N], so rot[N-1] is req[ptr-1] and rot[0] is req[ptr]
  assign doubled = {req, req};
  assign rot     = doubled[ptr +: N];

  always_comb begin
    found   = 1'b0;
    rot_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (rot[j]) begin
        found   = 1'b1;
        rot_idx = IDXW'(j);
      end
    end
  end

  assign win_idx = rot_idx + ptr;

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter for 16 requesters with hold timeout; optional grant
// counter is built only when RR_ARB_STATS_EN is defined.
module rr_req_arbiter #(
  parameter int N        = arb_pkg::N_REQ,
  parameter int IDXW     = arb_pkg::IDXW,
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic [IDXW-1:0] hold_cnt,
  output logic [15:0]     grant_count
);
  import arb_pkg::*;

  // With MAX_HOLD=0 there is no timeout, so hold_cnt simply saturates at all-ones
  localparam logic [IDXW-1:0] HOLD_SAT  = (MAX_HOLD == 0) ? IDXW'((1 << IDXW) - 1) : IDXW'(MAX_HOLD);
  localparam logic [IDXW-1:0] HOLD_LAST = IDXW'(MAX_HOLD - 1);

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic            found;
  logic [IDXW-1:0] win_idx;
  logic            owner_req;
  logic            other_req;
  logic            timeout_evt;
  logic            new_grant;

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .found   (found),
    .win_idx (win_idx)
  );

  assign owner_req   = req[ptr];
  assign other_req   = |(req & ~(N'(1) << ptr));
  assign timeout_evt = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && owner_req && other_req;

  // A release takes precedence over a coinciding timeout; both hand off to the pick
  always_comb begin
    new_grant = 1'b0;
    if (!rst && en) begin
      if (state == IDLE)
        new_grant = found;
      else if (!owner_req || timeout_evt)
        new_grant = found;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= IDXW'(NO_GRANT_IDX);
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
    end else if (!en || (state == OWN && !owner_req && !found)) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= IDXW'(NO_GRANT_IDX);
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
    end else if (new_grant) begin
      state     <= OWN;
      ptr       <= win_idx;
      gnt       <= N'(1) << win_idx;
      gnt_idx   <= win_idx;
      gnt_valid <= 1'b1;
      hold_cnt  <= '0;
    end else if (state == OWN && hold_cnt != HOLD_SAT) begin
      hold_cnt  <= hold_cnt + 1'b1;
    end
  end

`ifdef RR_ARB_STATS_EN
  logic [15:0] grant_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      grant_cnt_q <= '0;
    else if (new_grant && grant_cnt_q != 16'hFFFF)
      grant_cnt_q <= grant_cnt_q + 16'd1;
  end

  assign grant_count = grant_cnt_q;
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Scoreboard bench for rr_req_arbiter: a list-based round-robin model predicts
// every cycle's outputs and a monitor compares them independently of stimulus.
module tb_rr_req_arbiter;

  localparam int MAXH = 15;

  typedef struct {
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        valid;
    logic [3:0]  hold;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic [3:0]  hold_cnt;
  logic [15:0] grant_count;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];

  // Reference model: owner (-1 = none), last owner for rotation, owned cycles, grants
  int   m_owner = -1;
  int   m_last  = 0;
  int   m_held  = 0;
  int   m_cnt   = 0;

  rr_req_arbiter #(.N(16), .IDXW(4), .MAX_HOLD(MAXH)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .hold_cnt    (hold_cnt),
    .grant_count (grant_count)
  );

  always #5 clk = ~clk;

  function automatic int model_pick(input logic [15:0] r, input int from);
    for (int k = 1; k <= 16; k++) begin
      int i;
      i = (from - k + 16) % 16;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_grant(input int who);
    m_owner = who;
    m_last  = who;
    m_held  = 0;
    if (m_cnt < 65535) m_cnt++;
  endfunction

  function automatic void model_step(input logic r, input logic e, input logic [15:0] q);
    logic others;
    if (r) begin
      m_owner = -1; m_last = 0; m_held = 0; m_cnt = 0;
    end else if (!e) begin
      m_owner = -1; m_held = 0;
    end else if (m_owner < 0) begin
      if (q != 0) model_grant(model_pick(q, m_last));
    end else begin
      others = (q & ~(16'd1 << m_owner)) != 0;
      if (!q[m_owner]) begin
        if (others) model_grant(model_pick(q, m_last));
        else begin m_owner = -1; m_held = 0; end
      end else if (MAXH != 0 && m_held == MAXH - 1 && others) begin
        model_grant(model_pick(q, m_last));
      end else if (m_held < ((MAXH == 0) ? 15 : MAXH)) begin
        m_held++;
      end
    end
  endfunction

  function automatic exp_t model_outputs();
    exp_t x;
    x.gnt   = (m_owner < 0) ? 16'd0 : (16'd1 << m_owner);
    x.idx   = (m_owner < 0) ? 4'd0 : 4'(m_owner);
    x.valid = (m_owner >= 0);
    x.hold  = 4'(m_held);
`ifdef RR_ARB_STATS_EN
    x.cnt   = 16'(m_cnt);
`else
    x.cnt   = 16'd0;
`endif
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge and record what the next rising edge must produce
  task automatic applyStimulus(input logic r, input logic e, input logic [15:0] q);
    @(negedge clk);
    rst = r;
    en  = e;
    req = q;
    model_step(r, e, q);
    sb_q.push_back(model_outputs());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops one prediction per rising edge once stimulus has started
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        checkOutput("sb_gnt",         32'(gnt),         32'(x.gnt));
        checkOutput("sb_gnt_idx",     32'(gnt_idx),     32'(x.idx));
        checkOutput("sb_gnt_valid",   32'(gnt_valid),   32'(x.valid));
        checkOutput("sb_hold_cnt",    32'(hold_cnt),    32'(x.hold));
        checkOutput("sb_grant_count", 32'(grant_count), 32'(x.cnt));
      end
    end
  end

  initial begin
    logic [15:0] rq;
    logic        re, rr;
    int          drain;

    // Reset state
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0000); settle();
    checkOutput("reset_gnt",   32'(gnt), 32'h0);
    checkOutput("reset_valid", 32'(gnt_valid), 32'h0);

    // Highest index wins after reset, then zero-bubble handoff
    applyStimulus(1'b0, 1'b1, 16'h8001); settle();
    checkOutput("first_gnt", 32'(gnt), 32'h8000);
    checkOutput("first_idx", 32'(gnt_idx), 32'd15);
    applyStimulus(1'b0, 1'b1, 16'h0001); settle();
    checkOutput("handoff_gnt", 32'(gnt), 32'h0001);
    checkOutput("handoff_idx", 32'(gnt_idx), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0000); settle();
    checkOutput("release_idle", 32'(gnt_valid), 32'h0);

    // Fairness: each owner drops its bit for one cycle
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'hFFFF); settle();
    checkOutput("fair_start", 32'(gnt_idx), 32'd15);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, 1'b1, 16'hFFFF & ~(16'd1 << ((16 - k) % 16))); settle();
      checkOutput("fair_seq", 32'(gnt_idx), 32'((15 - k + 16) % 16));
    end

    // Timeout rotation between two contenders
    applyStimulus(1'b1, 1'b0, 16'h0000);
    for (int e = 1; e <= 31; e++) begin
      applyStimulus(1'b0, 1'b1, 16'h0003); settle();
      if (e == 1)  checkOutput("tmo_first", 32'(gnt), 32'h0002);
      if (e == 15) checkOutput("tmo_hold14", 32'(hold_cnt), 32'd14);
      if (e == 16) checkOutput("tmo_rotate", 32'(gnt), 32'h0001);
      if (e == 30) checkOutput("tmo_keep", 32'(gnt), 32'h0001);
      if (e == 31) checkOutput("tmo_back", 32'(gnt), 32'h0002);
    end

    // No contention: grant held, hold counter saturates
    for (int c = 0; c < 100; c++) applyStimulus(1'b0, 1'b1, 16'h0010);
    settle();
    checkOutput("solo_gnt",  32'(gnt), 32'h0010);
    checkOutput("solo_hold", 32'(hold_cnt), 32'd15);

    // Enable drop keeps ptr; resume searches from below it
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h0020); settle();
    checkOutput("en_owner5", 32'(gnt_idx), 32'd5);
    applyStimulus(1'b0, 1'b0, 16'h0020); settle();
    checkOutput("en_off_gnt", 32'(gnt), 32'h0);
    applyStimulus(1'b0, 1'b1, 16'h00FF); settle();
    checkOutput("en_resume", 32'(gnt_idx), 32'd4);

    // Reset during ownership
    applyStimulus(1'b0, 1'b1, 16'hFFFF);
    applyStimulus(1'b1, 1'b1, 16'hFFFF); settle();
    checkOutput("rst_own_gnt",   32'(gnt), 32'h0);
    checkOutput("rst_own_hold",  32'(hold_cnt), 32'h0);
    checkOutput("rst_own_count", 32'(grant_count), 32'h0);
    applyStimulus(1'b0, 1'b1, 16'hFFFF); settle();
    checkOutput("rst_regrant", 32'(gnt_idx), 32'd15);

    // Randomized traffic: bits toggle occasionally, rare enable drops and resets
    rq = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 16; b++)
        if ($urandom_range(0, 9) == 0) rq[b] = ~rq[b];
      re = ($urandom_range(0, 39) != 0);
      rr = ($urandom_range(0, 299) == 0);
      applyStimulus(rr, re, rq);
    end

    drain = 0;
    while (sb_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #3;
    if (sb_q.size() > 0) checkOutput("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
